// File: rtl/multiboot_pkg.sv
// rtl/multiboot_pkg.sv - shared state encoding and helpers for the multiboot controller
package multiboot_pkg;

    // Controller life cycle; FIRE is terminal until reset.
    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        HOLDOFF = 2'd1,
        SETUP   = 2'd2,
        FIRE    = 2'd3
    } mb_state_e;

    // Image slot index drives SB_WARMBOOT {S1,S0} directly.
    function automatic logic [1:0] slot_to_ws(input logic [1:0] slot);
        return slot;
    endfunction

    // Used to size the shared counters from the largest cycle count.
    function automatic longint unsigned max_u(input longint unsigned a, input longint unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mb_down_timer.sv
// rtl/mb_down_timer.sv - loadable down-counter with zero flag
module mb_down_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count_q, count_d;

    // Load wins over counting; the counter parks at zero instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/multiboot_ctrl.sv
// rtl/multiboot_ctrl.sv - iCE40 warm/multiboot sequencer with idle auto-boot and status LED
module multiboot_ctrl
    import multiboot_pkg::*;
#(
    parameter int unsigned NUM_IMAGES     = 4,
    parameter int unsigned DEFAULT_IMAGE  = 1,
    parameter bit          AUTO_BOOT_EN   = 1'b1,
    parameter int unsigned TIMEOUT_CYC    = 480000000,
    parameter int unsigned HOLDOFF_CYC    = 48000,
    parameter int unsigned SETUP_CYC      = 4,
    parameter int unsigned BLINK_HALF_CYC = 12000000
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       boot_req,
    input  logic [1:0] boot_sel,
    input  logic       usb_activity,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic       busy,
    output logic       sel_err,
    output logic       led
);

    localparam longint unsigned MAX_CYC =
        max_u(max_u(longint'(TIMEOUT_CYC), longint'(HOLDOFF_CYC)),
              max_u(longint'(BLINK_HALF_CYC), longint'(SETUP_CYC)));
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] TO_LAST     = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLDOFF_CYC - 1);
    localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] BLINK_LOAD  = CW'((BLINK_HALF_CYC > 0) ? BLINK_HALF_CYC - 1 : 0);
    // The first reload after reset is one shorter because the reset cycle itself counts.
    localparam logic [CW-1:0] BLINK_FIRST = CW'((BLINK_HALF_CYC > 1) ? BLINK_HALF_CYC - 2 : 0);
    localparam bit            BLINK_ONE   = (BLINK_HALF_CYC <= 1);
    localparam logic [CW-1:0] IDLE_MAX    = '1;

    if (NUM_IMAGES < 1 || NUM_IMAGES > 4) begin : g_bad_num_images
        $error("multiboot_ctrl: NUM_IMAGES must be 1..4");
    end
    if (DEFAULT_IMAGE >= NUM_IMAGES) begin : g_bad_default_image
        $error("multiboot_ctrl: DEFAULT_IMAGE must be below NUM_IMAGES");
    end
    if (HOLDOFF_CYC < 1) begin : g_bad_holdoff
        $error("multiboot_ctrl: HOLDOFF_CYC must be at least 1");
    end
    if (SETUP_CYC < 1) begin : g_bad_setup
        $error("multiboot_ctrl: SETUP_CYC must be at least 1");
    end

    mb_state_e     state_q, state_d;
    logic [CW-1:0] idle_q, idle_d;
    logic [1:0]    slot_q, slot_d;
    logic [1:0]    ws_q, ws_d;
    logic          boot_q, boot_d;
    logic          led_q, led_d;
    logic          blink_run_q, blink_run_d;
    logic          sel_err_c;

    logic          ph_load, ph_en, ph_done;
    logic [CW-1:0] ph_val;
    logic          bl_load, bl_en, bl_done;
    logic [CW-1:0] bl_val;
    logic          sel_ok;

    assign sel_ok = ({1'b0, boot_sel} < 3'(NUM_IMAGES));

    // HOLDOFF and SETUP never overlap, so one timer serves both phases.
    mb_down_timer #(.W(CW)) u_phase_timer (
        .clk      (clk_48mhz),
        .rst      (reset),
        .load     (ph_load),
        .load_val (ph_val),
        .en       (ph_en),
        .done     (ph_done)
    );

    mb_down_timer #(.W(CW)) u_blink_timer (
        .clk      (clk_48mhz),
        .rst      (reset),
        .load     (bl_load),
        .load_val (bl_val),
        .en       (bl_en),
        .done     (bl_done)
    );

    // Next-state, request arbitration, idle timeout and LED pattern.
    always_comb begin
        state_d     = state_q;
        idle_d      = idle_q;
        slot_d      = slot_q;
        led_d       = led_q;
        blink_run_d = blink_run_q;
        sel_err_c   = 1'b0;
        ph_load     = 1'b0;
        ph_val      = HOLD_LOAD;
        ph_en       = 1'b0;
        bl_load     = 1'b0;
        bl_val      = BLINK_LOAD;
        bl_en       = 1'b0;

        case (state_q)
            ARMED: begin
                idle_d      = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;
                blink_run_d = 1'b1;
                if (bl_done) begin
                    bl_load = 1'b1;
                    bl_val  = blink_run_q ? BLINK_LOAD : BLINK_FIRST;
                    if (blink_run_q || BLINK_ONE) begin
                        led_d = ~led_q;
                    end
                end else begin
                    bl_en = 1'b1;
                end
                // Explicit request beats activity, which beats the timeout.
                if (boot_req) begin
                    if (sel_ok) begin
                        slot_d  = boot_sel;
                        state_d = HOLDOFF;
                        ph_load = 1'b1;
                        ph_val  = HOLD_LOAD;
                    end else begin
                        sel_err_c = 1'b1;
                        idle_d    = '0;
                    end
                end else if (usb_activity) begin
                    idle_d = '0;
                end else if (AUTO_BOOT_EN && (idle_q == TO_LAST)) begin
                    slot_d  = 2'(DEFAULT_IMAGE);
                    state_d = HOLDOFF;
                    ph_load = 1'b1;
                    ph_val  = HOLD_LOAD;
                end
            end
            HOLDOFF: begin
                if (ph_done) begin
                    state_d = SETUP;
                    ph_load = 1'b1;
                    ph_val  = SETUP_LOAD;
                end else begin
                    ph_en = 1'b1;
                end
            end
            SETUP: begin
                if (ph_done) begin
                    state_d = FIRE;
                end else begin
                    ph_en = 1'b1;
                end
            end
            FIRE: begin
                state_d = FIRE;
            end
            default: begin
                state_d = ARMED;
            end
        endcase

        if (state_d != ARMED) begin
            led_d = 1'b1;
        end
        ws_d   = (state_d == SETUP || state_d == FIRE) ? slot_to_ws(slot_d) : 2'b00;
        boot_d = (state_d == FIRE);
    end

    // State and registered outputs; everything returns to idle values on reset.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state_q     <= ARMED;
            idle_q      <= '0;
            slot_q      <= 2'b00;
            ws_q        <= 2'b00;
            boot_q      <= 1'b0;
            led_q       <= 1'b0;
            blink_run_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            slot_q      <= slot_d;
            ws_q        <= ws_d;
            boot_q      <= boot_d;
            led_q       <= led_d;
            blink_run_q <= blink_run_d;
        end
    end

    assign wb_s1   = ws_q[1];
    assign wb_s0   = ws_q[0];
    assign wb_boot = boot_q;
    assign busy    = (state_q != ARMED);
    assign sel_err = sel_err_c & ~reset;
    assign led     = led_q;

endmodule

// File: tb/tb_multiboot_ctrl.sv
// tb/tb_multiboot_ctrl.sv - randomized self-checking bench with timestamp-based reference model
module tb_multiboot_ctrl;

    localparam int T_CYC = 100;
    localparam int H_CYC = 10;
    localparam int S_CYC = 4;
    localparam int B_CYC = 8;
    localparam int DEF   = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       boot_req = 1'b0;
    logic [1:0] boot_sel = 2'b00;
    logic       usb_activity = 1'b0;

    logic s1_a, s0_a, boot_a, busy_a, selerr_a, led_a;
    logic s1_b, s0_b, boot_b, busy_b, selerr_b, led_b;
    logic [5:0] obs [2];

    int checks = 0;
    int errors = 0;
    int scyc = 0;

    // Reference model: per DUT, acceptance timestamp and last idle-clear timestamp.
    int m_cyc = 0;
    bit m_acc [2];
    int m_t [2];
    int m_slot [2];
    int m_clr [2];

    always #5 clk = ~clk;

    multiboot_ctrl #(
        .NUM_IMAGES(4), .DEFAULT_IMAGE(DEF), .AUTO_BOOT_EN(1'b1), .TIMEOUT_CYC(T_CYC),
        .HOLDOFF_CYC(H_CYC), .SETUP_CYC(S_CYC), .BLINK_HALF_CYC(B_CYC)
    ) u_dut4 (
        .clk_48mhz(clk), .reset(reset), .boot_req(boot_req), .boot_sel(boot_sel),
        .usb_activity(usb_activity), .wb_s1(s1_a), .wb_s0(s0_a), .wb_boot(boot_a),
        .busy(busy_a), .sel_err(selerr_a), .led(led_a)
    );

    multiboot_ctrl #(
        .NUM_IMAGES(2), .DEFAULT_IMAGE(DEF), .AUTO_BOOT_EN(1'b1), .TIMEOUT_CYC(T_CYC),
        .HOLDOFF_CYC(H_CYC), .SETUP_CYC(S_CYC), .BLINK_HALF_CYC(B_CYC)
    ) u_dut2 (
        .clk_48mhz(clk), .reset(reset), .boot_req(boot_req), .boot_sel(boot_sel),
        .usb_activity(usb_activity), .wb_s1(s1_b), .wb_s0(s0_b), .wb_boot(boot_b),
        .busy(busy_b), .sel_err(selerr_b), .led(led_b)
    );

    // Packed view: {busy, s1, s0, boot, led, sel_err}
    assign obs[0] = {busy_a, s1_a, s0_a, boot_a, led_a, selerr_a};
    assign obs[1] = {busy_b, s1_b, s0_b, boot_b, led_b, selerr_b};

    function automatic int num_images(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic logic [5:0] model_out(input int i, input int c);
        logic [5:0] r;
        logic [1:0] ws;
        r = '0;
        if (!m_acc[i]) begin
            r[1] = ((c / B_CYC) % 2) == 1;
            r[0] = boot_req && (int'(boot_sel) >= num_images(i));
        end else begin
            ws     = 2'(m_slot[i]);
            r[5]   = 1'b1;
            r[4:3] = (c >= m_t[i] + 1 + H_CYC) ? ws : 2'b00;
            r[2]   = (c >= m_t[i] + 1 + H_CYC + S_CYC);
            r[1]   = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model with this cycle's inputs.
    initial begin : compare_proc
        forever begin
            @(negedge clk);
            if (reset) begin
                m_cyc = 0;
                for (int i = 0; i < 2; i++) begin
                    m_acc[i] = 1'b0; m_t[i] = 0; m_slot[i] = 0; m_clr[i] = -1;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("model dut%0d cyc%0d", i, m_cyc), 32'(obs[i]), 32'(model_out(i, m_cyc)));
                end
                for (int i = 0; i < 2; i++) begin
                    if (!m_acc[i]) begin
                        if (boot_req) begin
                            if (int'(boot_sel) < num_images(i)) begin
                                m_acc[i] = 1'b1; m_t[i] = m_cyc; m_slot[i] = int'(boot_sel);
                            end else begin
                                m_clr[i] = m_cyc;
                            end
                        end else if (usb_activity) begin
                            m_clr[i] = m_cyc;
                        end else if (m_cyc - m_clr[i] - 1 == T_CYC - 1) begin
                            m_acc[i] = 1'b1; m_t[i] = m_cyc; m_slot[i] = DEF;
                        end
                    end
                end
                m_cyc++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        scyc++;
        boot_req = 1'b0;
        usb_activity = 1'b0;
    endtask

    task automatic goto_cycle(input int k);
        while (scyc < k) next_cycle();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        scyc = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        boot_req = 1'b0;
        usb_activity = 1'b0;
        #1;
        chk("reset outputs dut4", 32'(obs[0]), 32'd0);
        chk("reset outputs dut2", 32'(obs[1]), 32'd0);
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    initial begin : stim
        // Valid request, slot 2 at cycle 5 (rejected on the 2-image DUT)
        do_reset();
        goto_cycle(5);
        boot_req = 1'b1; boot_sel = 2'd2;
        #2;
        chk("A busy before", 32'(busy_a), 32'd0);
        chk("A sel_err 2-image", 32'(selerr_b), 32'd1);
        chk("A sel_err 4-image", 32'(selerr_a), 32'd0);
        goto_cycle(6);  #2; chk("A busy c6", 32'(busy_a), 32'd1);
        goto_cycle(15); #2; chk("A ws c15", 32'({s1_a, s0_a}), 32'd0);
        goto_cycle(16); #2; chk("A ws c16", 32'({s1_a, s0_a}), 32'd2);
        goto_cycle(19); #2; chk("A boot c19", 32'(boot_a), 32'd0);
        goto_cycle(20); #2; chk("A boot c20", 32'(boot_a), 32'd1);
        goto_cycle(60); #2; chk("A boot sticky", 32'({boot_a, s1_a, s0_a}), 32'b110);

        // Periodic activity keeps auto-boot away; LED blinks
        do_reset();
        goto_cycle(7);  #2; chk("B led c7", 32'(led_a), 32'd0);
        goto_cycle(8);  #2; chk("B led c8", 32'(led_a), 32'd1);
        goto_cycle(16); #2; chk("B led c16", 32'(led_a), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            goto_cycle(50 * k - 1);
            usb_activity = 1'b1;
        end
        goto_cycle(1000); #2;
        chk("B no boot", 32'({boot_a, boot_b, busy_a, busy_b}), 32'd0);

        // Auto-boot after idle timeout
        do_reset();
        goto_cycle(99);  #2; chk("C busy c99", 32'(busy_a), 32'd0);
        goto_cycle(100); #2; chk("C busy c100", 32'(busy_a), 32'd1);
        goto_cycle(113); #2; chk("C boot c113", 32'(boot_a), 32'd0);
        goto_cycle(114); #2; chk("C boot+ws c114", 32'({boot_a, s1_a, s0_a}), 32'b101);

        // Rejected slot on the 2-image DUT restarts its idle timer
        do_reset();
        goto_cycle(3);
        boot_req = 1'b1; boot_sel = 2'd3;
        #2; chk("D sel_err pulse", 32'({selerr_b, selerr_a}), 32'b10);
        goto_cycle(4);   #2; chk("D after reject", 32'({busy_b, selerr_b, busy_a}), 32'b001);
        goto_cycle(103); #2; chk("D busy c103", 32'(busy_b), 32'd0);
        goto_cycle(104); #2; chk("D busy c104", 32'(busy_b), 32'd1);

        // boot_req on the expiry cycle wins over the default slot
        do_reset();
        goto_cycle(99);
        boot_req = 1'b1; boot_sel = 2'd0;
        goto_cycle(110); #2; chk("E ws slot0", 32'({busy_a, s1_a, s0_a}), 32'b100);
        goto_cycle(114); #2; chk("E boot slot0", 32'({boot_a, s1_a, s0_a, boot_b, s1_b, s0_b}), 32'b100100);

        // Activity on the expiry cycle wins
        do_reset();
        goto_cycle(99);
        usb_activity = 1'b1;
        goto_cycle(100); #2; chk("F busy c100", 32'(busy_a), 32'd0);
        goto_cycle(199); #2; chk("F busy c199", 32'(busy_a), 32'd0);
        goto_cycle(200); #2; chk("F busy c200", 32'(busy_a), 32'd1);

        // Reset mid-HOLDOFF drops the request immediately
        do_reset();
        goto_cycle(2);
        boot_req = 1'b1; boot_sel = 2'd1;
        goto_cycle(6);
        #1; reset = 1'b1;
        #1; chk("G async reset", 32'({obs[0], obs[1]}), 32'd0);
        release_reset();
        for (int k = 1; k <= 6; k++) begin
            goto_cycle(30 * k);
            usb_activity = 1'b1;
        end
        goto_cycle(200); #2;
        chk("G no boot after reset", 32'({boot_a, busy_a, boot_b, busy_b}), 32'd0);

        // Randomized episodes
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int k = 0; k < 300; k++) begin
                if ($urandom_range(39, 0) == 0) usb_activity = 1'b1;
                if ($urandom_range(119, 0) == 0) begin
                    boot_req = 1'b1;
                    boot_sel = 2'($urandom_range(3, 0));
                end
                next_cycle();
            end
        end

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
